// File: rtl/scanout_ctrl.sv
// Raster scan-out controller: h/v timing, linear video read address, registered
// pixel/sync outputs, and a frame-synchronous double-buffer flip handshake.
module scanout_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = 16,
  parameter int H_BLANK    = 4,
  parameter int V_ACTIVE   = 16,
  parameter int V_BLANK    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flip_req,
  output logic                  flip_ack,
  output logic                  switch,
  output logic [ADDR_WIDTH-1:0] vADDR,
  input  logic [DATA_WIDTH-1:0] vDATA,
  output logic [DATA_WIDTH-1:0] pix_out,
  output logic                  pix_valid,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, PENDING, ACK} state_t;

  logic [HW-1:0]         h_q, h_d;
  logic [VW-1:0]         v_q, v_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  state_t                state_q, state_d;
  logic                  sw_q, sw_d;
  logic                  ack_q;
  logic                  h_last, v_last, wrap, active;

  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);
  assign wrap   = h_last && v_last;
  assign active = (h_q < H_ACT) && (v_q < V_ACT);

  always_comb begin
    h_d    = h_last ? '0 : h_q + HW'(1);
    v_d    = v_q;
    addr_d = addr_q;
    if (h_last) v_d = v_last ? '0 : v_q + VW'(1);
    if (wrap)        addr_d = '0;
    else if (active) addr_d = addr_q + ADDR_WIDTH'(1);
  end

  // The flip only commits on the wrap cycle, so the buffer never swaps mid-frame.
  always_comb begin
    state_d = state_q;
    sw_d    = sw_q;
    if (en) begin
      case (state_q)
        IDLE, PENDING: begin
          if (!flip_req) begin
            state_d = IDLE;
          end else if (wrap) begin
            state_d = ACK;
            sw_d    = ~sw_q;
          end else begin
            state_d = PENDING;
          end
        end
        ACK:     if (!flip_req) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q         <= '0;
      v_q         <= '0;
      addr_q      <= '0;
      pix_out     <= '0;
      pix_valid   <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      state_q     <= IDLE;
      sw_q        <= 1'b0;
      ack_q       <= 1'b0;
    end else if (en) begin
      h_q         <= h_d;
      v_q         <= v_d;
      addr_q      <= addr_d;
      pix_out     <= vDATA;
      pix_valid   <= active;
      hsync       <= (h_q >= H_ACT);
      vsync       <= (v_q >= V_ACT);
      frame_start <= (h_q == '0) && (v_q == '0);
      state_q     <= state_d;
      sw_q        <= sw_d;
      ack_q       <= (state_d == ACK);
    end
  end

  assign vADDR    = addr_q;
  assign switch   = sw_q;
  assign flip_ack = ack_q;
endmodule

// File: doc/scanout_ctrl.md
SCANOUT_CTRL -- requirements
Module: scanout_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning video read-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning pixel data width.
REQ-003 SHALL have parameter H_ACTIVE, default 16, meaning active pixels per line.
REQ-004 SHALL have parameter H_BLANK, default 4, meaning blank pixels per line.
REQ-005 SHALL have parameter V_ACTIVE, default 16, meaning active lines per frame; H_ACTIVE*V_ACTIVE SHALL be <= 2^ADDR_WIDTH.
REQ-006 SHALL have parameter V_BLANK, default 2, meaning blank lines per frame.
REQ-007 SHALL use one clock and a synchronous, active-high reset.
REQ-008 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-009 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-010 SHALL have port en, input, 1 bit: pixel-rate enable.
REQ-011 SHALL have port flip_req, input, 1 bit: writer requests a buffer swap (level).
REQ-012 SHALL have port flip_ack, output, 1 bit: swap done (level, 4-phase).
REQ-013 SHALL have port switch, output, 1 bit: buffer select; drives the memory mux select.
REQ-014 SHALL have port vADDR, output, ADDR_WIDTH: video read address to the mux video port.
REQ-015 SHALL have port vDATA, input, DATA_WIDTH: read data from the mux video port, combinational from vADDR.
REQ-016 SHALL have port pix_out, output, DATA_WIDTH: registered pixel.
REQ-017 SHALL have port pix_valid, output, 1 bit: pix_out is an active pixel.
REQ-018 SHALL have ports hsync and vsync, output, 1 bit each: blanking indicators aligned with pix_out.
REQ-019 SHALL have port frame_start, output, 1 bit: one-enable pulse on the first active pixel of a frame.

Function
REQ-020 SHALL hold counters h (0..H_ACTIVE+H_BLANK-1) and v (0..V_ACTIVE+V_BLANK-1); all state advances only on cycles with en=1, and every register holds when en=0.
REQ-021 SHALL increment h on each enabled cycle; at the last h it SHALL wrap h to 0 and increment v; at the last h with the last v ("wrap cycle") it SHALL wrap both to 0.
REQ-022 SHALL drive vADDR from a linear address counter that is 0 at h=0,v=0, increments on each enabled active cycle (h<H_ACTIVE, v<V_ACTIVE), holds in blanking, and returns to 0 on the wrap cycle.
REQ-023 SHALL register pix_out<=vDATA, pix_valid<=active, hsync<=(h>=H_ACTIVE) and vsync<=(v>=V_ACTIVE) on enabled cycles, giving 1-enable latency from vADDR to pix_out.
REQ-024 SHALL register frame_start<=(h==0 && v==0) on enabled cycles, so it aligns with the first pixel's pix_out.
REQ-025 SHALL implement a flip FSM with states IDLE, PENDING and ACK.
REQ-026 In IDLE with flip_req=1 and not a wrap cycle, the FSM SHALL go to PENDING.
REQ-027 In IDLE or PENDING with flip_req=1 on a wrap cycle, the FSM SHALL toggle switch and go to ACK.
REQ-028 In PENDING with flip_req=0 (request withdrawn), the FSM SHALL return to IDLE without toggling.
REQ-029 In ACK, flip_ack SHALL be 1; the FSM SHALL go to IDLE when flip_req=0, and flip_req held high SHALL NOT cause a second toggle.
REQ-030 flip_ack SHALL be a registered output equal to (state==ACK).
REQ-031 switch SHALL change only on a wrap cycle, never mid-frame.
REQ-032 The FSM SHALL act only on enabled cycles.

Reset
REQ-033 On rst=1 at a clock edge, regardless of en, the block SHALL set h=0, v=0, vADDR=0, pix_out=0, pix_valid=0, hsync=0, vsync=0, frame_start=0, switch=0, flip_ack=0 and state=IDLE.
REQ-034 Reset mid-frame or mid-flip SHALL discard any pending request and return switch to 0.

Verification
Bench parameters: H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=1; each frame is 24 enabled cycles.
REQ-035 Free-run with en=1 from reset: vADDR SHALL step 0,1,2,3 per line (holding in blanking), reach 11 on the last active pixel, and return to 0 at cycle 24. pix_valid SHALL be high for exactly 12 cycles per frame. frame_start SHALL pulse at cycles 1, 25, ...
REQ-036 Model vDATA = vADDR+8'h40: pix_out SHALL be 8'h40..8'h4B in order, each appearing one cycle after its address.
REQ-037 Assert flip_req at cycle 5 and hold it: switch SHALL go 0->1 only at cycle 24 and flip_ack SHALL rise then. With flip_req kept high through a second frame, there SHALL be no second toggle. Dropping flip_req SHALL make flip_ack fall on the next cycle.
REQ-038 Pulse flip_req for 1 cycle at cycle 5, then deassert: the FSM SHALL go PENDING then IDLE, and switch SHALL stay 0.
REQ-039 Toggle en 50% (alternating): the frame SHALL take 48 clocks, with the address and pixel sequence identical to REQ-036.
REQ-040 Assert rst at cycle 10 while PENDING: every output SHALL be 0 the next cycle, and no flip SHALL occur at the following frame wrap.
